crc5_0x25_frame_check: RTL

//  Receive-side checker for CRC-5 (poly 0x25, x^5+x^2+1, MSB-first, init 0) framed serial data.

---
 rtl/crc5_0x25_frame_check.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/crc5_0x25_frame_check.sv
// Receive-side CRC-5 (x^5+x^2+1, MSB-first, init 0) frame checker.
// Collects DATA_W payload bits plus 5 CRC bits per frame and reports payload and verdict.
module crc5_0x25_frame_check #(
  parameter int DATA_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sof,
  input  logic              din,
  output logic [DATA_W-1:0] data_out,
  output logic [4:0]        rx_crc,
  output logic              frame_vld,
  output logic              crc_ok,
  output logic              crc_err,
  output logic              busy,
  output logic              abort,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_e;

  // The CHECK phase counts to 5, so the counter never drops below 3 bits.
  localparam int CW_RAW = $clog2(DATA_W + 1);
  localparam int CW     = (CW_RAW < 3) ? 3 : CW_RAW;
  localparam logic [CW-1:0] PAY_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] CRC_LAST = CW'(4);

  state_e            state_q, state_d;
  logic [4:0]        rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] payload_q, payload_d;
  logic [3:0]        crc_q, crc_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [4:0]        rx_crc_q, rx_crc_d;
  logic              frame_vld_q, frame_vld_d;
  logic              crc_ok_q, crc_ok_d;
  logic              crc_err_q, crc_err_d;
  logic              abort_q, abort_d;

  logic [DATA_W-1:0] payload_shift;
  logic [4:0]        rem_step;
  logic [4:0]        rem_start;
  logic [4:0]        crc_field;

  function automatic logic [4:0] crc_step(input logic [4:0] rem, input logic bit_in);
    logic fb;
    fb = rem[4] ^ bit_in;
    return {rem[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
  endfunction

  if (DATA_W == 1) begin : g_pay_one
    assign payload_shift = din;
  end else begin : g_pay_wide
    assign payload_shift = {payload_q[DATA_W-2:0], din};
  end

  assign rem_step  = crc_step(rem_q, din);
  assign rem_start = crc_step(5'b00000, din);
  assign crc_field = {crc_q, din};

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    payload_d   = payload_q;
    crc_d       = crc_q;
    data_out_d  = data_out_q;
    rx_crc_d    = rx_crc_q;
    crc_ok_d    = crc_ok_q;
    crc_err_d   = crc_err_q;
    frame_vld_d = 1'b0;
    abort_d     = 1'b0;

    if (en) begin
      if (sof) begin
        // A new sof always wins: restart from scratch, dropping any frame in flight.
        abort_d   = (state_q != ST_IDLE);
        rem_d     = rem_start;
        payload_d = payload_shift;
        if (PAY_LAST == '0) begin
          state_d = ST_CHECK;
          cnt_d   = '0;
        end else begin
          state_d = ST_PAYLOAD;
          cnt_d   = CW'(1);
        end
      end else begin
        case (state_q)
          ST_PAYLOAD: begin
            rem_d     = rem_step;
            payload_d = payload_shift;
            if (cnt_q == PAY_LAST) begin
              state_d = ST_CHECK;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          ST_CHECK: begin
            rem_d = rem_step;
            crc_d = crc_field[3:0];
            if (cnt_q == CRC_LAST) begin
              state_d     = ST_IDLE;
              cnt_d       = '0;
              data_out_d  = payload_q;
              rx_crc_d    = crc_field;
              crc_ok_d    = (rem_step == 5'b00000);
              crc_err_d   = (rem_step != 5'b00000);
              frame_vld_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      cnt_q       <= '0;
      payload_q   <= '0;
      crc_q       <= '0;
      data_out_q  <= '0;
      rx_crc_q    <= '0;
      frame_vld_q <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      payload_q   <= payload_d;
      crc_q       <= crc_d;
      data_out_q  <= data_out_d;
      rx_crc_q    <= rx_crc_d;
      frame_vld_q <= frame_vld_d;
      crc_ok_q    <= crc_ok_d;
      crc_err_q   <= crc_err_d;
      abort_q     <= abort_d;
    end
  end

  assign data_out  = data_out_q;
  assign rx_crc    = rx_crc_q;
  assign frame_vld = frame_vld_q;
  assign crc_ok    = crc_ok_q;
  assign crc_err   = crc_err_q;
  assign abort     = abort_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
